// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle RV32 control FSM with memory handshake, bus timeout and trap
module multicycle_control_unit #(
    parameter int OPCODE_W      = 7,
    parameter int MEM_HANDSHAKE = 1,
    parameter int TIMEOUT       = 16,
    parameter int STATE_W       = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                ir_write,
    output logic                adr_src,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic [1:0]          result_src,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          imm_src,
    output logic                illegal,
    output logic                bus_error,
    output logic [STATE_W-1:0]  state
);

    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] OP_RTYPE  = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] OP_ITYPE  = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] OP_JAL    = OPCODE_W'(7'b1101111);
    localparam logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(7'b1100011);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                illegal_q, illegal_d;
    logic                bus_error_q, bus_error_d;
    logic                rdy;
    logic                mem_state;

    assign rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            wait_q      <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q;

        case (state_q)
            S_FETCH:    if (rdy) state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_LOAD || opcode == OP_STORE) state_d = S_MEMADR;
                else if (opcode == OP_RTYPE)                 state_d = S_EXECR;
                else if (opcode == OP_ITYPE)                 state_d = S_EXECI;
                else if (opcode == OP_JAL)                   state_d = S_JAL;
                else if (opcode == OP_BRANCH)                state_d = S_BEQ;
                else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (rdy) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (rdy) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase

        // The final stalled cycle traps; a ready on that same cycle still completes.
        if (mem_state && !rdy) begin
            if (TIMEOUT > 0 && wait_q == WAIT_W'(TIMEOUT - 1)) begin
                state_d     = S_TRAP;
                bus_error_d = 1'b1;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end

        if (state_d != state_q) wait_d = '0;
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB: reg_write = 1'b1;
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = zero;
            end
            default: ;
        endcase
    end

    always_comb begin
        imm_src = 2'b00;
        if (opcode == OP_STORE)       imm_src = 2'b01;
        else if (opcode == OP_BRANCH) imm_src = 2'b10;
        else if (opcode == OP_JAL)    imm_src = 2'b11;
    end

    assign illegal   = illegal_q;
    assign bus_error = bus_error_q;
    assign state     = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       a_pcw, a_irw, a_adr, a_mr, a_mw, a_rw, a_ill, a_be;
    logic [1:0] a_rs, a_sa, a_sb, a_op, a_imm;
    logic [3:0] a_st;
    logic       b_pcw, b_irw, b_adr, b_mr, b_mw, b_rw, b_ill, b_be;
    logic [1:0] b_rs, b_sa, b_sb, b_op, b_imm;
    logic [3:0] b_st;

    multicycle_control_unit dut16 (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(a_pcw), .ir_write(a_irw), .adr_src(a_adr), .mem_read(a_mr),
        .mem_write(a_mw), .reg_write(a_rw), .result_src(a_rs), .alu_src_a(a_sa),
        .alu_src_b(a_sb), .alu_op(a_op), .imm_src(a_imm), .illegal(a_ill),
        .bus_error(a_be), .state(a_st)
    );

    multicycle_control_unit #(.TIMEOUT(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(b_pcw), .ir_write(b_irw), .adr_src(b_adr), .mem_read(b_mr),
        .mem_write(b_mw), .reg_write(b_rw), .result_src(b_rs), .alu_src_a(b_sa),
        .alu_src_b(b_sb), .alu_op(b_op), .imm_src(b_imm), .illegal(b_ill),
        .bus_error(b_be), .state(b_st)
    );

    always #5 clk = ~clk;

    wire [21:0] vec_a = {a_pcw, a_irw, a_adr, a_mr, a_mw, a_rw, a_rs, a_sa, a_sb, a_op, a_imm, a_ill, a_be, a_st};
    wire [21:0] vec_b = {b_pcw, b_irw, b_adr, b_mr, b_mw, b_rw, b_rs, b_sa, b_sb, b_op, b_imm, b_ill, b_be, b_st};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: control word per state, and the state path each opcode walks after DECODE.
    typedef struct packed {
        logic       pcw, irw, adr, mr, mw, rw;
        logic [1:0] rs, sa, sb, op;
    } ctrl_t;
    ctrl_t ctrl_tab [12];

    int m_state [2];
    int m_wait  [2];
    bit m_ill   [2];
    bit m_be    [2];
    int m_path  [2][4];
    int m_len   [2];
    int m_pos   [2];

    function automatic logic [1:0] ref_imm(input logic [6:0] op);
        if (op == 7'b0100011) return 2'b01;
        if (op == 7'b1100011) return 2'b10;
        if (op == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [21:0] exp_vec(input int k);
        ctrl_t c;
        c = ctrl_tab[m_state[k]];
        if (m_state[k] == 0) begin
            c.pcw = mem_ready;
            c.irw = mem_ready;
        end
        if (m_state[k] == 10) c.pcw = zero;
        return {c, ref_imm(opcode), m_ill[k], m_be[k], 4'(m_state[k])};
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0; m_wait[k] = 0; m_ill[k] = 0; m_be[k] = 0;
            m_len[k] = 0; m_pos[k] = 0;
        end
    endtask

    task automatic m_step(input int k, input int tmo, input bit rdy);
        int s;
        bit adv;
        s   = m_state[k];
        adv = 0;
        if (s == 11) begin
        end else if (s == 0 || s == 3 || s == 5) begin
            if (rdy) adv = 1;
            else if (tmo > 0 && m_wait[k] + 1 == tmo) begin
                m_state[k] = 11; m_be[k] = 1; m_wait[k] = 0;
            end else m_wait[k]++;
        end else adv = 1;
        if (adv) begin
            m_wait[k] = 0;
            if (s == 0) m_state[k] = 1;
            else if (s == 1) begin
                m_pos[k] = 0;
                case (opcode)
                    7'b0000011: begin m_path[k] = '{2, 3, 4, 0}; m_len[k] = 3; end
                    7'b0100011: begin m_path[k] = '{2, 5, 0, 0}; m_len[k] = 2; end
                    7'b0110011: begin m_path[k] = '{6, 7, 0, 0}; m_len[k] = 2; end
                    7'b0010011: begin m_path[k] = '{8, 7, 0, 0}; m_len[k] = 2; end
                    7'b1101111: begin m_path[k] = '{9, 7, 0, 0}; m_len[k] = 2; end
                    7'b1100011: begin m_path[k] = '{10, 0, 0, 0}; m_len[k] = 1; end
                    default:    m_len[k] = 0;
                endcase
                if (m_len[k] == 0) begin
                    m_state[k] = 11; m_ill[k] = 1;
                end else begin
                    m_state[k] = m_path[k][0]; m_pos[k] = 1;
                end
            end else if (m_pos[k] < m_len[k]) begin
                m_state[k] = m_path[k][m_pos[k]];
                m_pos[k]++;
            end else m_state[k] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        m_reset();
    endtask

    typedef struct {
        logic [6:0] op;
        logic       z;
        int         n;
        int         st  [5];
        int         pcw [5];
        int         rw  [5];
        int         mw  [5];
    } vec_t;
    vec_t tab [7];

    logic [6:0] ops [8];
    int burst, trapcnt;

    initial begin
        ctrl_tab[0]  = '{pcw:1, irw:1, adr:0, mr:1, mw:0, rw:0, rs:2, sa:0, sb:2, op:0};
        ctrl_tab[1]  = '{pcw:0, irw:0, adr:0, mr:0, mw:0, rw:0, rs:0, sa:1, sb:1, op:0};
        ctrl_tab[2]  = '{pcw:0, irw:0, adr:0, mr:0, mw:0, rw:0, rs:0, sa:2, sb:1, op:0};
        ctrl_tab[3]  = '{pcw:0, irw:0, adr:1, mr:1, mw:0, rw:0, rs:0, sa:0, sb:0, op:0};
        ctrl_tab[4]  = '{pcw:0, irw:0, adr:0, mr:0, mw:0, rw:1, rs:1, sa:0, sb:0, op:0};
        ctrl_tab[5]  = '{pcw:0, irw:0, adr:1, mr:0, mw:1, rw:0, rs:0, sa:0, sb:0, op:0};
        ctrl_tab[6]  = '{pcw:0, irw:0, adr:0, mr:0, mw:0, rw:0, rs:0, sa:2, sb:0, op:2};
        ctrl_tab[7]  = '{pcw:0, irw:0, adr:0, mr:0, mw:0, rw:1, rs:0, sa:0, sb:0, op:0};
        ctrl_tab[8]  = '{pcw:0, irw:0, adr:0, mr:0, mw:0, rw:0, rs:0, sa:2, sb:1, op:2};
        ctrl_tab[9]  = '{pcw:1, irw:0, adr:0, mr:0, mw:0, rw:0, rs:0, sa:1, sb:2, op:0};
        ctrl_tab[10] = '{pcw:0, irw:0, adr:0, mr:0, mw:0, rw:0, rs:0, sa:2, sb:0, op:1};
        ctrl_tab[11] = '0;

        tab[0] = '{7'b0000011, 1'b0, 5, '{0, 1, 2, 3, 4}, '{1, 0, 0, 0, 0}, '{0, 0, 0, 0, 1}, '{0, 0, 0, 0, 0}};
        tab[1] = '{7'b0100011, 1'b0, 4, '{0, 1, 2, 5, 0}, '{1, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 1, 0}};
        tab[2] = '{7'b0110011, 1'b0, 4, '{0, 1, 6, 7, 0}, '{1, 0, 0, 0, 0}, '{0, 0, 0, 1, 0}, '{0, 0, 0, 0, 0}};
        tab[3] = '{7'b0010011, 1'b1, 4, '{0, 1, 8, 7, 0}, '{1, 0, 0, 0, 0}, '{0, 0, 0, 1, 0}, '{0, 0, 0, 0, 0}};
        tab[4] = '{7'b1100011, 1'b1, 3, '{0, 1, 10, 0, 0}, '{1, 0, 1, 0, 0}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}};
        tab[5] = '{7'b1100011, 1'b0, 3, '{0, 1, 10, 0, 0}, '{1, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}};
        tab[6] = '{7'b1101111, 1'b0, 4, '{0, 1, 9, 7, 0}, '{1, 0, 1, 0, 0}, '{0, 0, 0, 1, 0}, '{0, 0, 0, 0, 0}};

        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1101111, 7'b1100011, 7'b1111111, 7'b0110111};

        reset = 1'b1; opcode = 7'b0000011; zero = 1'b0; mem_ready = 1'b1;
        m_reset();
        #2;
        chk("reset_vec16", 32'(vec_a), 32'(exp_vec(0)));
        chk("reset_vec4", 32'(vec_b), 32'(exp_vec(1)));
        #10;
        reset = 1'b0;
        #1;

        // Table-driven instruction sequences with memory always ready.
        foreach (tab[i]) begin
            opcode = tab[i].op; zero = tab[i].z; mem_ready = 1'b1;
            for (int j = 0; j < tab[i].n; j++) begin
                #1;
                chk($sformatf("tab%0d_state%0d", i, j), 32'(a_st), 32'(tab[i].st[j]));
                chk($sformatf("tab%0d_state4_%0d", i, j), 32'(b_st), 32'(tab[i].st[j]));
                chk($sformatf("tab%0d_pcw%0d", i, j), 32'(a_pcw), 32'(tab[i].pcw[j]));
                chk($sformatf("tab%0d_rw%0d", i, j), 32'(a_rw), 32'(tab[i].rw[j]));
                chk($sformatf("tab%0d_mw%0d", i, j), 32'(a_mw), 32'(tab[i].mw[j]));
                if (tab[i].op == 7'b1101111) chk($sformatf("tab%0d_imm%0d", i, j), 32'(a_imm), 32'd3);
                if (tab[i].st[j] == 4) chk("lw_result_src", 32'(a_rs), 32'd1);
                tick();
            end
        end
        chk("seq_end_fetch", 32'(a_st), 32'd0);

        // FETCH stalled three cycles, then proceeds.
        do_reset();
        mem_ready = 1'b0; opcode = 7'b0110011;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("stall_state", 32'(a_st), 32'd0);
            chk("stall_irw", 32'(a_irw), 32'd0);
            chk("stall_pcw", 32'(a_pcw), 32'd0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("stall_release_irw", 32'(a_irw), 32'd1);
        tick();
        chk("stall_decode", 32'(a_st), 32'd1);

        // MEMREAD timeout on the TIMEOUT=4 instance.
        do_reset();
        opcode = 7'b0000011; mem_ready = 1'b1;
        repeat (3) tick();
        chk("to_memread", 32'(b_st), 32'd3);
        mem_ready = 1'b0;
        repeat (3) tick();
        chk("to_pre_state", 32'(b_st), 32'd3);
        tick();
        chk("to_trap", 32'(b_st), 32'd11);
        chk("to_bus_error", 32'(b_be), 32'd1);
        chk("to_illegal", 32'(b_ill), 32'd0);
        chk("to_wide_still_wait", 32'(a_st), 32'd3);
        chk("to_wide_no_error", 32'(a_be), 32'd0);
        do_reset();
        #1;
        chk("to_reset_state", 32'(b_st), 32'd0);
        chk("to_reset_be", 32'(b_be), 32'd0);
        chk("to_reset_ill", 32'(b_ill), 32'd0);

        // Ready arriving on the last allowed cycle completes the access.
        mem_ready = 1'b1;
        repeat (3) tick();
        mem_ready = 1'b0;
        repeat (3) tick();
        mem_ready = 1'b1;
        tick();
        chk("to_edge_memwb", 32'(b_st), 32'd4);
        chk("to_edge_no_be", 32'(b_be), 32'd0);

        // Unsupported opcode traps and stays sticky.
        do_reset();
        opcode = 7'b1111111; mem_ready = 1'b1;
        tick();
        chk("ill_decode", 32'(a_st), 32'd1);
        tick();
        chk("ill_trap", 32'(a_st), 32'd11);
        chk("ill_flag", 32'(a_ill), 32'd1);
        repeat (3) tick();
        chk("ill_sticky_state", 32'(a_st), 32'd11);
        chk("ill_sticky_flag", 32'(a_ill), 32'd1);
        chk("ill_no_be", 32'(a_be), 32'd0);
        chk("ill_trap_strobes", 32'({a_mr, a_mw, a_rw, a_pcw}), 32'd0);

        // Asynchronous reset while in MEMWRITE.
        do_reset();
        opcode = 7'b0100011;
        repeat (3) tick();
        chk("sw_memwrite", 32'(a_st), 32'd5);
        chk("sw_mw", 32'(a_mw), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_state", 32'(a_st), 32'd0);
        chk("async_rst_mw", 32'(a_mw), 32'd0);
        reset = 1'b0;
        m_reset();
        #1;

        // Randomized run against the reference model.
        burst = 0; trapcnt = 0;
        for (int it = 0; it < 3000; it++) begin
            if ((m_state[0] == 0 || m_state[0] == 11) && (m_state[1] == 0 || m_state[1] == 11)
                && ($urandom % 4 == 0))
                opcode = ops[$urandom % 8];
            if (burst > 0) begin
                mem_ready = 1'b0; burst--;
            end else if ($urandom % 40 == 0) begin
                burst = $urandom_range(1, 20); mem_ready = 1'b0;
            end else mem_ready = ($urandom % 5 != 0);
            zero = 1'($urandom % 2);
            #1;
            chk("rand_vec16", 32'(vec_a), 32'(exp_vec(0)));
            chk("rand_vec4", 32'(vec_b), 32'(exp_vec(1)));
            if ((a_mr && a_mw) || (a_rw && a_mw)) chk("rand_exclusive", 32'd1, 32'd0);
            @(posedge clk);
            m_step(0, 16, mem_ready);
            m_step(1, 4, mem_ready);
            #1;
            if (m_state[0] == 11 || m_state[1] == 11) trapcnt++;
            else trapcnt = 0;
            if (trapcnt > 3 || $urandom % 400 == 0) begin
                do_reset();
                trapcnt = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multi-cycle successor to the single-cycle control decoder. It sequences each RV32 base instruction (lw, sw, R-type, I-type ALU, beq, jal) through a Moore FSM that shares one ALU and one unified memory port. It adds a memory ready handshake, a parametrised bus-timeout counter and an illegal-opcode/bus-error trap state. It sits between the instruction register (opcode source) and the multi-cycle datapath muxes and enables.

Parameters:
OPCODE_W, 7, opcode field width.
MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored and treated as 1.
TIMEOUT, 16, maximum consecutive mem_ready-low cycles in a memory state before trapping; 0 disables the timeout.
STATE_W, 4, width of the state debug output.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; forces FETCH
opcode  input  OPCODE_W  instruction[6:0] from the instruction register; stable from DECODE onward
zero  input  1  ALU zero flag
mem_ready  input  1  memory access completes this cycle
pc_write  output  1  PC register enable
ir_write  output  1  instruction register and oldPC enable
adr_src  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
reg_write  output  1  register file write enable
result_src  output  2  result select: 00 = ALUOut, 01 = data, 10 = ALU result
alu_src_a  output  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1
alu_src_b  output  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4
alu_op  output  2  00 = add, 01 = sub/compare, 10 = funct decode
imm_src  output  2  00 = I, 01 = S, 10 = B, 11 = J
illegal  output  1  trap caused by an unsupported opcode (sticky)
bus_error  output  1  trap caused by a memory timeout (sticky)
state  output  STATE_W  current state encoding (debug)

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, TRAP=11.
- Single state register, updated on the rising edge of clk. Asynchronous reset sets state to FETCH, clears the wait counter, and clears illegal and bus_error.
- Outputs are decoded from state only, except:
  - pc_write and ir_write in FETCH, which are gated by mem_ready;
  - pc_write in BEQ, which equals zero.
- All outputs not listed for a state are 0. The reset output values are the FETCH decode with mem_ready applied.
- imm_src is decoded combinationally from opcode in every state: 0100011 gives 01, 1100011 gives 10, 1101111 gives 11, all other opcodes give 00.
- Per-state outputs and transitions:
  - FETCH: adr_src=0, mem_read=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, ir_write=pc_write=mem_ready. Go to DECODE when rdy, else stay.
  - DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch/jump target into ALUOut). Next state by opcode: 0000011 or 0100011 → MEMADR, 0110011 → EXECR, 0010011 → EXECI, 1101111 → JAL, 1100011 → BEQ, any other opcode → TRAP with illegal set.
  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next state is MEMREAD if opcode=0000011, else MEMWRITE.
  - MEMREAD: adr_src=1, mem_read=1. Go to MEMWB when rdy.
  - MEMWB: result_src=01, reg_write=1. Go to FETCH.
  - MEMWRITE: adr_src=1, mem_write=1. Go to FETCH when rdy.
  - EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Go to ALUWB.
  - EXECI: alu_src_a=10, alu_src_b=01, alu_op=10. Go to ALUWB.
  - ALUWB: result_src=00, reg_write=1. Go to FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Go to ALUWB, which writes oldPC+4 to rd.
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero. Go to FETCH.
  - TRAP: all strobes 0. Stay in TRAP until reset.
- "rdy" above means: mem_ready when MEM_HANDSHAKE=1, constant 1 when MEM_HANDSHAKE=0.
- Wait counter, width sized to hold TIMEOUT:
  - Increments each cycle spent in FETCH, MEMREAD or MEMWRITE with rdy low.
  - Clears on any state change.
  - If it reaches TIMEOUT with rdy still low (TIMEOUT>0), the next state is TRAP and bus_error is set.
  - If mem_ready rises on the same cycle the count hits TIMEOUT, the access completes and no trap is taken.
- mem_read and mem_write are never high together. reg_write and mem_write are never high together.

Test Plan:
- lw, mem_ready=1: state sequence 0,1,2,3,4,0. reg_write=1 and result_src=01 only in cycle 5. Total 5 cycles.
- beq, zero=1: state sequence 0,1,10,0 with pc_write=1 in BEQ. Repeat with zero=0: pc_write=0 in BEQ.
- jal: state sequence 0,1,9,7,0. pc_write=1 in JAL, reg_write=1 in ALUWB, imm_src=11 throughout.
- FETCH with mem_ready low for 3 cycles (TIMEOUT=16): state stays 0 for 3 cycles with ir_write=pc_write=0. Reaches DECODE on the cycle after mem_ready=1.
- TIMEOUT=4, MEMREAD with mem_ready held low: TRAP entered after 4 low cycles, bus_error=1, illegal=0. Reset pulse returns state to 0 with both flags cleared.
- opcode 7'b1111111: sequence 0,1,11. illegal=1 and stays sticky. Asserting reset while in MEMWRITE immediately forces state 0 with mem_write=0.
